// File: rtl/notch_ctrl_pkg.sv
// Shared definitions for the notch filter sample sequencer: FSM state
// encoding and default sizing constants.
package notch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        BYP  = 2'd3
    } state_e;

    localparam int DEF_DATA_SIZE = 24;
    localparam int DEF_TIMEOUT   = 255;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/notch_seq_ctrl_if.sv
// Bundle of the converter-side, filter-side and status signals around the
// sequencer; slave is the sequencer, master is whatever surrounds it.
interface notch_seq_ctrl_if
    import notch_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int CNT_W     = DEF_CNT_W
) ();

    logic [DATA_SIZE-1:0] in_data;
    logic                 in_stb;
    logic                 bypass;
    logic [DATA_SIZE-1:0] flt_data_in;
    logic                 flt_sample;
    logic [DATA_SIZE-1:0] flt_data_out;
    logic                 flt_done;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_stb;
    logic                 busy;
    logic [CNT_W-1:0]     overrun_cnt;
    logic                 timeout_err;
    logic                 clear_err;

    modport slave (
        input  in_data, in_stb, bypass, flt_data_out, flt_done, clear_err,
        output flt_data_in, flt_sample, out_data, out_stb, busy,
               overrun_cnt, timeout_err
    );

    modport master (
        output in_data, in_stb, bypass, flt_data_out, flt_done, clear_err,
        input  flt_data_in, flt_sample, out_data, out_stb, busy,
               overrun_cnt, timeout_err
    );

endinterface

// File: rtl/seq_watchdog.sv
// Completion watchdog: cleared when the filter is triggered, counts while
// waiting, and flags expiry once the count reaches TIMEOUT-1.
module seq_watchdog
    import notch_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Holds at LAST so a stalled filter never wraps back to a fresh window.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/notch_seq_ctrl.sv
// Sample sequencer in front of the adaptive notch filter: loads each sample,
// triggers the filter, waits with a watchdog and emits one result strobe.
module notch_seq_ctrl
    import notch_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    notch_seq_ctrl_if.slave bus
);

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] hold_q, hold_d;
    logic [DATA_SIZE-1:0] flt_in_q, flt_in_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic                 out_stb_q, out_stb_d;
    logic                 done_q;
    logic                 terr_q, terr_d, terr_set;
    logic [CNT_W-1:0]     ovr_q, ovr_d;
    logic                 wd_clear, wd_en, wd_expire, complete;

    assign wd_clear = (state_q == LOAD);
    assign wd_en    = (state_q == WAIT);
    // Only a fresh rising edge counts; a level left over from the previous
    // sample must not complete the current one.
    assign complete = wd_en && bus.flt_done && !done_q;

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (wd_clear),
        .enable_i (wd_en),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        flt_in_d   = flt_in_q;
        out_data_d = out_data_q;
        out_stb_d  = 1'b0;
        terr_set   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_stb) begin
                    hold_d = bus.in_data;
                    if (bus.bypass) begin
                        state_d = BYP;
                    end else begin
                        flt_in_d = bus.in_data;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: state_d = WAIT;
            WAIT: begin
                // Completion takes priority over a same-cycle watchdog expiry.
                if (complete) begin
                    out_data_d = bus.flt_data_out;
                    out_stb_d  = 1'b1;
                    state_d    = IDLE;
                end else if (wd_expire) begin
                    out_data_d = hold_q;
                    out_stb_d  = 1'b1;
                    terr_set   = 1'b1;
                    state_d    = IDLE;
                end
            end
            BYP: begin
                out_data_d = hold_q;
                out_stb_d  = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes outside IDLE are dropped; clear_err overrides both counters.
    always_comb begin
        ovr_d  = ovr_q;
        terr_d = terr_q | terr_set;
        if (bus.in_stb && (state_q != IDLE) && (ovr_q != '1)) begin
            ovr_d = ovr_q + 1'b1;
        end
        if (bus.clear_err) begin
            ovr_d  = '0;
            terr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            flt_in_q   <= '0;
            out_data_q <= '0;
            out_stb_q  <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            flt_in_q   <= flt_in_d;
            out_data_q <= out_data_d;
            out_stb_q  <= out_stb_d;
            done_q     <= bus.flt_done;
            terr_q     <= terr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.flt_data_in = flt_in_q;
    assign bus.flt_sample  = (state_q == LOAD);
    assign bus.out_data    = out_data_q;
    assign bus.out_stb     = out_stb_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.overrun_cnt = ovr_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_notch_seq_ctrl.sv
// Scoreboard bench for notch_seq_ctrl: a driver predicts each result from the
// sample/bypass/filter-delay rules, a monitor checks every out_stb against it.
module tb_notch_seq_ctrl;
    import notch_ctrl_pkg::*;

    localparam int DW      = 24;
    localparam int TO      = 16;
    localparam int CW      = 3;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    notch_seq_ctrl_if #(.DATA_SIZE(DW), .CNT_W(CW)) bus ();

    notch_seq_ctrl #(
        .DATA_SIZE (DW),
        .TIMEOUT   (TO),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        bit            terr;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] res;
        int            dly;
        bit            hold;
        bit            stale;
    } flt_t;

    exp_t sb[$];
    flt_t fq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_until = 0;
    int   ovr_m = 0;
    bit   terr_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus. The model: a sample is taken only when the
    // previous one has produced its output; result appears 1 cycle after
    // acceptance for bypass, dly+1 when the filter answers within TO cycles,
    // otherwise TO+1 with the raw sample and a sticky timeout flag.
    task automatic drive(input bit stb, input logic [DW-1:0] d, input bit byp, input int dly,
                         input logic [DW-1:0] res, input bit hold, input bit stale, input bit clr);
        int   e;
        bit   tmo;
        exp_t x;
        flt_t f;
        @(posedge clk);
        #1;
        bus.in_stb    = stb;
        bus.in_data   = d;
        bus.bypass    = byp;
        bus.clear_err = clr;
        e = cyc + 1;
        if (clr) terr_m = 1'b0;
        if (stb && (e > busy_until)) begin
            tmo    = !byp && ((dly < 1) || (dly > TO));
            x.data = (byp || tmo) ? d : res;
            x.cyc  = e + (byp ? 1 : (tmo ? TO + 1 : dly + 1));
            x.terr = terr_m | tmo;
            terr_m = x.terr;
            busy_until = x.cyc;
            sb.push_back(x);
            if (!byp) begin
                f.din = d; f.res = res; f.dly = dly; f.hold = hold; f.stale = stale;
                fq.push_back(f);
            end
        end else if (stb && (ovr_m < CNT_MAX)) begin
            ovr_m++;
        end
        if (clr) ovr_m = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic quiet_check(input string tag);
        idle(1);
        while (cyc < busy_until + 1) idle(1);
        @(negedge clk);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_overrun_cnt"}, 64'(bus.overrun_cnt), 64'(ovr_m));
        check({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'(terr_m));
        check({tag, "_pending"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic reset_pulse(input int n);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.in_stb    = 1'b0;
        bus.clear_err = 1'b0;
        sb.delete();
        fq.delete();
        busy_until = 0;
        ovr_m      = 0;
        terr_m     = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("rst_flt_data_in", 64'(bus.flt_data_in), 64'd0);
            check("rst_flt_sample", 64'(bus.flt_sample), 64'd0);
            check("rst_out_data", 64'(bus.out_data), 64'd0);
            check("rst_out_stb", 64'(bus.out_stb), 64'd0);
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_overrun_cnt", 64'(bus.overrun_cnt), 64'd0);
            check("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: every out_stb consumes exactly one predicted result.
    initial begin : monitor
        exp_t x;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((reset === 1'b1) && (bus.out_stb === 1'b1)) begin
                check("out_stb_back_to_back", 64'(prev), 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_stb_unexpected at cycle %0d: got out_data %0h, expected no strobe",
                             cyc, bus.out_data);
                end else begin
                    x = sb.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(x.data));
                    check("out_stb_cycle", 64'(cyc), 64'(x.cyc));
                    check("timeout_err_at_out", 64'(bus.timeout_err), 64'(x.terr));
                    check("busy_at_out", 64'(bus.busy), 64'd0);
                end
            end
            prev = (bus.out_stb === 1'b1);
        end
    end

    // Filter core model: answers each trigger after its programmed delay.
    initial begin : filter_model
        flt_t f;
        bit   raise;
        int   last;
        bus.flt_done     = 1'b0;
        bus.flt_data_out = '0;
        forever begin
            @(negedge clk);
            if ((reset === 1'b1) && (bus.flt_sample === 1'b1)) begin
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL flt_sample_unexpected at cycle %0d: got 1, expected 0", cyc);
                end else begin
                    f = fq.pop_front();
                    check("flt_data_in", 64'(bus.flt_data_in), 64'(f.din));
                    raise = (f.dly >= 1) && (f.dly <= TO);
                    last  = raise ? f.dly : 1;
                    for (int k = 1; k <= last; k++) begin
                        @(negedge clk);
                        if (k == 1) check("flt_sample_one_pulse", 64'(bus.flt_sample), 64'd0);
                        if (f.stale && (k == 2)) bus.flt_done = 1'b0;
                        if (raise && (k == f.dly)) begin
                            bus.flt_done     = 1'b1;
                            bus.flt_data_out = f.res;
                        end
                    end
                    if (raise && !f.hold) begin
                        @(negedge clk);
                        bus.flt_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_time_limit at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        bit            r_stb, r_byp;
        int            r_dly;
        logic [DW-1:0] r_d, r_res;
        bus.in_stb    = 1'b0;
        bus.in_data   = '0;
        bus.bypass    = 1'b0;
        bus.clear_err = 1'b0;

        reset_pulse(3);
        idle(2);

        // Normal filtered sample
        drive(1'b1, 24'h123456, 1'b0, 12, 24'h0ABCDE, 1'b0, 1'b0, 1'b0);
        quiet_check("normal");

        // Bypass
        drive(1'b1, 24'h7FFFFF, 1'b1, 0, '0, 1'b0, 1'b0, 1'b0);
        quiet_check("bypass");

        // Filter answers on the last watchdog cycle, then immediately
        drive(1'b1, 24'h00F00D, 1'b0, TO, 24'h555AAA, 1'b0, 1'b0, 1'b0);
        quiet_check("tie");
        drive(1'b1, 24'h800001, 1'b0, 1, 24'h3C3C3C, 1'b0, 1'b0, 1'b0);
        quiet_check("fast");

        // Filter never answers: timeout, then clear
        drive(1'b1, 24'hCAFE01, 1'b0, 0, 24'h111111, 1'b0, 1'b0, 1'b0);
        quiet_check("timeout");
        drive(1'b0, '0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b1);
        quiet_check("timeout_clear");

        // Three overruns while waiting, one on the return cycle, then an
        // immediate acceptance on the first IDLE cycle
        drive(1'b1, 24'h246801, 1'b0, 10, 24'h13579B, 1'b0, 1'b0, 1'b0);
        idle(1);
        repeat (3) drive(1'b1, 24'hBAD000, 1'b0, 5, 24'hBAD111, 1'b0, 1'b0, 1'b0);
        while (cyc + 1 < busy_until) idle(1);
        drive(1'b1, 24'hBAD222, 1'b0, 5, 24'hBAD333, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 24'h0F0F0F, 1'b1, 0, '0, 1'b0, 1'b0, 1'b0);
        quiet_check("overrun4");

        // Overrun saturation during a timeout, clear, then clear beats increment
        drive(1'b1, 24'h424242, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 24'hDEAD00, 1'b1, 0, '0, 1'b0, 1'b0, 1'b0);
        quiet_check("saturate");
        drive(1'b0, '0, 1'b0, 0, '0, 1'b0, 1'b0, 1'b1);
        quiet_check("sat_clear");
        drive(1'b1, 24'h606060, 1'b1, 0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 24'h707070, 1'b1, 0, '0, 1'b0, 1'b0, 1'b1);
        quiet_check("clear_wins");

        // Stale done: level left high by the previous sample
        drive(1'b1, 24'h010203, 1'b0, 5, 24'hA1A2A3, 1'b1, 1'b0, 1'b0);
        quiet_check("stale_first");
        drive(1'b1, 24'h040506, 1'b0, 6, 24'hB1B2B3, 1'b0, 1'b1, 1'b0);
        quiet_check("stale_second");

        // Reset in the middle of a wait, then normal operation resumes
        drive(1'b1, 24'h999999, 1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 24'h888888, 1'b0, 3, '0, 1'b0, 1'b0, 1'b0);
        idle(2);
        reset_pulse(3);
        drive(1'b1, 24'h314159, 1'b0, 4, 24'h271828, 1'b0, 1'b0, 1'b0);
        quiet_check("after_reset");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_stb = ($urandom_range(0, 99) < 30);
            r_byp = ($urandom_range(0, 2) == 0);
            r_dly = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
            r_d   = DW'($urandom);
            r_res = DW'($urandom);
            drive(r_stb, r_d, r_byp, r_dly, r_res, 1'b0, 1'b0, 1'b0);
        end
        quiet_check("random");
        check("filter_items_left", 64'(fq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
